uart_word_loader: RTL and testbench
===================================

Name: uart_word_loader

Overview:
- Consumes the byte stream from the UART receiver (one-cycle byte-valid pulse plus an 8-bit data byte).
- Packs every four bytes, MSB first, into a 32-bit word and writes it to sequential word addresses of instruction/data memory through a req/ack handshake.
- Acts as the serial program loader for the multi-cycle CPU.
- Handles an end-of-load marker, an inter-byte timeout, a one-byte holding buffer and a full-memory stop.

Parameters:
- ADDR_W, 10, word-address width of the target memory.
- TIMEOUT_CYC, 1000000, idle clk cycles allowed between bytes of one partial word (10 ms at 100 MHz).
- END_WORD, 32'hFFFFFFFF, assembled word that terminates loading and is not written.

Ports:
- clk  in  1  system clock, 100 MHz, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  loader enable (level).
- rx_ready  in  1  one-cycle pulse, rx_data valid.
- rx_data  in  8  received byte.
- mem_ack  in  1  memory accepted current write.
- mem_we  out  1  write request, held until mem_ack.
- mem_addr  out  ADDR_W  word address of current write.
- mem_wdata  out  32  word being written.
- busy  out  1  high in COLLECT or WRITE.
- done  out  1  load finished, held until en=0.
- word_count  out  ADDR_W+1  words written since start.
- timeout_err  out  1  sticky: partial word discarded.
- overrun_err  out  1  sticky: byte dropped.

Behaviour:
- Reset (async): state IDLE; every output 0; internal byte count, pending-byte flag and shift register cleared.
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered.

IDLE:
- rx_ready is ignored.
- en=1 moves to COLLECT and clears mem_addr, word_count, byte count, both error flags and done.

COLLECT:
- On rx_ready: shift <= {shift[23:0], rx_data}; byte_cnt++ (2-bit).
- When the 4th byte arrives, the assembled word is compared to END_WORD the next cycle.
  - Match: go to DONE with no write.
  - Otherwise: go to WRITE with mem_wdata=word and mem_we=1, driven on the second edge after the 4th rx_ready.
- Timeout: a counter resets on every rx_ready and runs only while byte_cnt!=0. When it reaches TIMEOUT_CYC: byte_cnt=0, partial word discarded, timeout_err=1, state stays COLLECT.
- en=0: go to IDLE at once and discard the partial word.

WRITE:
- mem_we, mem_addr and mem_wdata are held stable until mem_ack=1 is sampled.
- On that edge: mem_we=0, word_count++.
  - If mem_addr was all ones: go to DONE; mem_addr is not incremented.
  - Else: mem_addr++; go to IDLE if en=0, otherwise COLLECT.
- en=0 during WRITE does not abort; the handshake completes first.
- rx_ready during WRITE: the byte goes into a one-byte pending buffer.
  - If the buffer is already full: the new byte is dropped and overrun_err=1.
  - On entry to COLLECT, the pending byte is shifted in on the transition edge (byte_cnt=1) and the buffer is cleared.
- A byte arriving on the same edge as mem_ack is treated as pending and is consumed on entry to COLLECT.

DONE:
- done=1, busy=0; rx_ready is ignored.
- en=0 moves to IDLE and clears done on the next edge.

Width and boundary rules:
- word_count saturates naturally at 2^ADDR_W.
- mem_addr never wraps.
- rx_ready coinciding with a timeout expiry: the byte wins; counter resets and byte_cnt increments normally.

Test Plan:
- Two words: en=1, bytes 12 34 56 78 9A BC DE F0, mem_ack 2 cycles after each mem_we -> writes addr0=0x12345678, addr1=0x9ABCDEF0; word_count=2; mem_we rises exactly 2 edges after each 4th rx_ready.
- Terminator: bytes 01 02 03 04 FF FF FF FF -> one write (addr0=0x01020304), then done=1, busy=0, word_count=1, no second mem_we; drop en -> done=0 next cycle.
- Timeout: TIMEOUT_CYC=100; bytes AA BB, then 100 idle cycles -> timeout_err=1, no write. Then bytes 11 22 33 44 -> write addr0=0x11223344.
- Pending/overrun: hold mem_ack=0; pulse rx_ready with 55 then 66 during WRITE -> overrun_err=1. After ack, bytes 77 88 99 -> next word 0x55778899.
- Full memory: ADDR_W=2; send 4 non-terminator words -> addresses 0..3 written, done=1 after 4th ack, mem_addr=3, word_count=4; a 5th word is ignored.
- Reset mid-WRITE: assert rst while mem_we=1 -> mem_we, busy, mem_addr and word_count go to 0 immediately (asynchronously); after release the loader is in IDLE.

Source files
------------

// File: rtl/uart_word_loader.sv
// Serial program loader: packs UART bytes MSB-first into 32-bit words and
// writes them to consecutive memory word addresses over a req/ack handshake.
module uart_word_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [31:0] END_WORD    = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state, state_n;
    logic [31:0]       shift, shift_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic              word_full, word_full_n;
    logic              pend_valid, pend_valid_n;
    logic [7:0]        pend_byte, pend_byte_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wdata_n;
    logic              busy_n, done_n;
    logic [ADDR_W:0]   word_count_n;
    logic              timeout_err_n, overrun_err_n;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shift       <= '0;
            byte_cnt    <= '0;
            word_full   <= 1'b0;
            pend_valid  <= 1'b0;
            pend_byte   <= '0;
            tmo_cnt     <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_count  <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            byte_cnt    <= byte_cnt_n;
            word_full   <= word_full_n;
            pend_valid  <= pend_valid_n;
            pend_byte   <= pend_byte_n;
            tmo_cnt     <= tmo_cnt_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            busy        <= busy_n;
            done        <= done_n;
            word_count  <= word_count_n;
            timeout_err <= timeout_err_n;
            overrun_err <= overrun_err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n       = state;
        shift_n       = shift;
        byte_cnt_n    = byte_cnt;
        word_full_n   = word_full;
        pend_valid_n  = pend_valid;
        pend_byte_n   = pend_byte;
        tmo_cnt_n     = tmo_cnt;
        mem_we_n      = mem_we;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        word_count_n  = word_count;
        timeout_err_n = timeout_err;
        overrun_err_n = overrun_err;

        case (state)
            S_IDLE: begin
                pend_valid_n = 1'b0;
                if (en) begin
                    state_n       = S_COLLECT;
                    mem_addr_n    = '0;
                    word_count_n  = '0;
                    byte_cnt_n    = '0;
                    word_full_n   = 1'b0;
                    tmo_cnt_n     = '0;
                    timeout_err_n = 1'b0;
                    overrun_err_n = 1'b0;
                end
            end
            S_COLLECT: begin
                if (!en) begin
                    state_n      = S_IDLE;
                    byte_cnt_n   = '0;
                    word_full_n  = 1'b0;
                    tmo_cnt_n    = '0;
                    pend_valid_n = 1'b0;
                end else if (word_full) begin
                    // Complete word is judged one cycle after its last byte
                    word_full_n = 1'b0;
                    if (shift == END_WORD) begin
                        state_n = S_DONE;
                    end else begin
                        state_n     = S_WRITE;
                        mem_we_n    = 1'b1;
                        mem_wdata_n = shift;
                        if (rx_ready) begin
                            pend_valid_n = 1'b1;
                            pend_byte_n  = rx_data;
                        end
                    end
                end else if (rx_ready) begin
                    shift_n    = {shift[23:0], rx_data};
                    byte_cnt_n = byte_cnt + 2'd1;
                    tmo_cnt_n  = '0;
                    if (byte_cnt == 2'd3) word_full_n = 1'b1;
                end else if (byte_cnt != 2'd0) begin
                    if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        byte_cnt_n    = '0;
                        tmo_cnt_n     = '0;
                        timeout_err_n = 1'b1;
                    end else begin
                        tmo_cnt_n = tmo_cnt + TMO_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (rx_ready) begin
                    if (pend_valid) begin
                        overrun_err_n = 1'b1;
                    end else begin
                        pend_valid_n = 1'b1;
                        pend_byte_n  = rx_data;
                    end
                end
                if (mem_ack) begin
                    mem_we_n     = 1'b0;
                    word_count_n = word_count + CNT_W'(1);
                    if (&mem_addr) begin
                        state_n      = S_DONE;
                        pend_valid_n = 1'b0;
                    end else begin
                        mem_addr_n = mem_addr + ADDR_W'(1);
                        if (!en) begin
                            state_n      = S_IDLE;
                            pend_valid_n = 1'b0;
                        end else begin
                            state_n    = S_COLLECT;
                            tmo_cnt_n  = '0;
                            byte_cnt_n = '0;
                            // Buffered byte (or one landing on the ack edge) starts the next word
                            if (pend_valid || rx_ready) begin
                                shift_n      = {shift[23:0], (pend_valid ? pend_byte : rx_data)};
                                byte_cnt_n   = 2'd1;
                                pend_valid_n = 1'b0;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                pend_valid_n = 1'b0;
                if (!en) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n == S_COLLECT) || (state_n == S_WRITE);
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader: expected writes are queued by the
// stimulus and checked by an independent monitor at each accepted write.
module tb_uart_word_loader;

    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              mem_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              timeout_err;
    logic              overrun_err;

    int  errors = 0;
    int  checks = 0;
    bit  ack_hold = 1'b0;
    int  wait_cnt = 0;
    logic [33:0] exp_q[$];

    uart_word_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(100), .END_WORD(32'hFFFFFFFF)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_ready(rx_ready), .rx_data(rx_data),
        .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .word_count(word_count),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic wait_we_low();
        int n = 0;
        while (mem_we && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (mem_we) chk("we_low_timeout", 32'(mem_we), 32'd0);
    endtask

    // Sends a word and checks that the write request appears exactly two edges after the 4th byte
    task automatic send_word(input logic [31:0] w, input bit wr);
        send4(w);
        chk("we_early", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk("we_rise", 32'(mem_we), 32'(wr));
        if (wr) wait_we_low();
    endtask

    task automatic restart();
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;
    endtask

    // Memory responder: acknowledges two cycles after the request unless held off
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_we && !ack_hold) begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every accepted write must match the next queued expectation
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (mem_we && mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 32'(mem_addr), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[33:32]));
                    chk("wr_data", mem_wdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_errs", 32'({timeout_err, overrun_err}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // IDLE ignores bytes
        send4(32'h01020304);
        chk("idle_busy", 32'(busy), 32'd0);

        // Two words
        en = 1'b1;
        @(posedge clk); #1;
        chk("collect_busy", 32'(busy), 32'd1);
        push_exp(2'd0, 32'h12345678);
        send_word(32'h12345678, 1'b1);
        push_exp(2'd1, 32'h9ABCDEF0);
        send_word(32'h9ABCDEF0, 1'b1);
        chk("two_word_count", 32'(word_count), 32'd2);

        // Terminator
        restart();
        push_exp(2'd0, 32'h01020304);
        send_word(32'h01020304, 1'b1);
        send_word(32'hFFFFFFFF, 1'b0);
        chk("term_done", 32'(done), 32'd1);
        chk("term_busy", 32'(busy), 32'd0);
        chk("term_word_count", 32'(word_count), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("term_no_we", 32'(mem_we), 32'd0);
        en = 1'b0;
        @(posedge clk); #1;
        chk("term_done_clear", 32'(done), 32'd0);

        // Timeout
        en = 1'b1;
        @(posedge clk); #1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (99) @(posedge clk);
        #1;
        chk("tmo_not_yet", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_no_we", 32'(mem_we), 32'd0);
        push_exp(2'd0, 32'h11223344);
        send_word(32'h11223344, 1'b1);

        // Pending byte and overrun
        restart();
        chk("restart_tmo_clear", 32'(timeout_err), 32'd0);
        ack_hold = 1'b1;
        push_exp(2'd0, 32'hA1A2A3A4);
        send4(32'hA1A2A3A4);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_we", 32'(mem_we), 32'd1);
        send_byte(8'h55);
        chk("pend_no_overrun", 32'(overrun_err), 32'd0);
        send_byte(8'h66);
        chk("overrun_err", 32'(overrun_err), 32'd1);
        chk("hold_wdata", mem_wdata, 32'hA1A2A3A4);
        ack_hold = 1'b0;
        wait_we_low();
        push_exp(2'd1, 32'h55778899);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        @(posedge clk); #1;
        chk("pend_we_rise", 32'(mem_we), 32'd1);
        wait_we_low();

        // Full memory
        restart();
        for (int i = 0; i < 4; i++) begin
            push_exp(ADDR_W'(i), 32'hC0DE0000 + 32'(i));
            send_word(32'hC0DE0000 + 32'(i), 1'b1);
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_addr", 32'(mem_addr), 32'd3);
        chk("full_word_count", 32'(word_count), 32'd4);
        send_word(32'h0BADF00D, 1'b0);
        chk("full_count_hold", 32'(word_count), 32'd4);

        // Reset during a held write
        restart();
        push_exp(2'd0, 32'h13579BDF);
        send_word(32'h13579BDF, 1'b1);
        ack_hold = 1'b1;
        send4(32'h2468ACE0);
        @(posedge clk); #1;
        chk("rstw_we_before", 32'(mem_we), 32'd1);
        chk("rstw_addr_before", 32'(mem_addr), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstw_we", 32'(mem_we), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_addr", 32'(mem_addr), 32'd0);
        chk("rstw_word_count", 32'(word_count), 32'd0);
        en = 1'b0;
        ack_hold = 1'b0;
        #5 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstw_idle_busy", 32'(busy), 32'd0);
        chk("rstw_idle_we", 32'(mem_we), 32'd0);
        en = 1'b1;
        @(posedge clk); #1;
        push_exp(2'd0, 32'hFEEDBEEF);
        send_word(32'hFEEDBEEF, 1'b1);

        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
